eq_round_ctrl: RTL and testbench

//   Sequences one comparison round for the eq4 equality datapath.
//   - Takes two push buttons and a 4-bit switch bus.
//   - Latches operand A on push1 and operand B on push2.
//   - Strobes the external comparator once per round and shows the verdict on the LED for a fixed time.
//   - Keeps saturating match/mismatch tallies.
//   - Aborts a round if B is not entered in time.

---
 rtl/eq_round_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_eq_round_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eq_round_ctrl.sv
// -----------------------------------------------------------------------------
// eq_round_ctrl
//
// Sequences one comparison round for the eq4 equality datapath. The user enters
// operand A with a rising edge on push1 and operand B with a rising edge on
// push2. The controller then strobes the external comparator for one cycle,
// latches its verdict onto the LED for HOLD cycles and updates saturating
// match/mismatch tallies. If B is not entered within TIMEOUT cycles, the round
// is aborted and err is shown for HOLD cycles instead.
//
// Parameters
//   W        operand width (switch bus / comparator width)
//   CW       width of match_cnt / miss_cnt
//   HOLD     cycles the verdict or the error indication is held (>= 1)
//   TIMEOUT  maximum cycles spent waiting for B before aborting (>= 2)
//
// Ports
//   clk        in   1    single clock, rising edge
//   reset      in   1    synchronous, active-high; clears every register
//   no         in   W    operand switches
//   push1      in   1    level; a rising edge enters A
//   push2      in   1    level; a rising edge enters B
//   eq_in      in   1    comparator result, combinational on op_a/op_b
//   op_a       out  W    latched operand A
//   op_b       out  W    latched operand B
//   cmp_valid  out  1    one-cycle strobe; eq_in is sampled at the end of it
//   ledpin     out  1    verdict display (1 = equal)
//   err        out  1    timeout indication
//   busy       out  1    high whenever a round is in progress
//   match_cnt  out  CW   saturating count of equal rounds
//   miss_cnt   out  CW   saturating count of unequal rounds
// -----------------------------------------------------------------------------
module eq_round_ctrl #(
  parameter int W       = 4,
  parameter int CW      = 8,
  parameter int HOLD    = 8,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [W-1:0]  no,
  input  logic          push1,
  input  logic          push2,
  input  logic          eq_in,
  output logic [W-1:0]  op_a,
  output logic [W-1:0]  op_b,
  output logic          cmp_valid,
  output logic          ledpin,
  output logic          err,
  output logic          busy,
  output logic [CW-1:0] match_cnt,
  output logic [CW-1:0] miss_cnt
);

  // One timer serves both the WAIT_B timeout and the SHOW/ERR hold period,
  // so it is sized for the larger of the two terminal counts.
  localparam int MAXC = (HOLD > TIMEOUT) ? HOLD : TIMEOUT;
  localparam int TW   = $clog2(MAXC + 1);

  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT_B = 3'd1,
    CMP    = 3'd2,
    SHOW   = 3'd3,
    ERR    = 3'd4
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          push1_q;
  logic          push2_q;
  logic          r1;
  logic          r2;

  // Tallies stop at all-ones instead of wrapping back to zero.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (&v) sat_inc = v;
    else    sat_inc = v + CW'(1);
  endfunction

  // Rising-edge detect: a held button produces exactly one edge.
  assign r1 = push1 & ~push1_q;
  assign r2 = push2 & ~push2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      push1_q   <= 1'b0;
      push2_q   <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      cmp_valid <= 1'b0;
      ledpin    <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      match_cnt <= '0;
      miss_cnt  <= '0;
    end else begin
      push1_q   <= push1;
      push2_q   <= push2;
      // cmp_valid is only ever a single-cycle pulse out of WAIT_B.
      cmp_valid <= 1'b0;

      case (state)
        IDLE: begin
          busy   <= 1'b0;
          ledpin <= 1'b0;
          err    <= 1'b0;
          // B before A, or both at once, is ignored.
          if (r1 && !r2) begin
            op_a  <= no;
            timer <= '0;
            busy  <= 1'b1;
            state <= WAIT_B;
          end
        end

        WAIT_B: begin
          timer <= timer + TIMER_ONE;
          // A valid B edge wins over a timeout landing in the same cycle.
          if (r2 && !r1) begin
            op_b      <= no;
            cmp_valid <= 1'b1;
            state     <= CMP;
          end else if (r1 && !r2) begin
            op_a  <= no;
            timer <= '0;
          end else if (timer == TO_LAST) begin
            timer  <= '0;
            err    <= 1'b1;
            ledpin <= 1'b0;
            state  <= ERR;
          end
        end

        CMP: begin
          // eq_in reflects op_a/op_b latched on the previous edge.
          ledpin <= eq_in;
          timer  <= '0;
          if (eq_in) match_cnt <= sat_inc(match_cnt);
          else       miss_cnt  <= sat_inc(miss_cnt);
          state  <= SHOW;
        end

        SHOW: begin
          timer <= timer + TIMER_ONE;
          // A new A entry cuts the display short and starts the next round.
          if (r1 && !r2) begin
            ledpin <= 1'b0;
            op_a   <= no;
            timer  <= '0;
            state  <= WAIT_B;
          end else if (timer == HOLD_LAST) begin
            ledpin <= 1'b0;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end

        ERR: begin
          timer  <= timer + TIMER_ONE;
          ledpin <= 1'b0;
          if (timer == HOLD_LAST) begin
            err   <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          // Unused encodings fall back to a quiet IDLE.
          timer  <= '0;
          ledpin <= 1'b0;
          err    <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eq_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_eq_round_ctrl
//
// Directed bench for eq_round_ctrl. A default-parameter instance is exercised
// through match, mismatch, ordering/overwrite, timeout, abort, simultaneous-edge
// and mid-round reset scenarios. A second instance with CW=2 shares the same
// stimulus and is used to observe counter saturation.
// -----------------------------------------------------------------------------
module tb_eq_round_ctrl;

  localparam int W       = 4;
  localparam int CW      = 8;
  localparam int HOLD    = 8;
  localparam int TIMEOUT = 16;

  logic          clk;
  logic          reset;
  logic [W-1:0]  no;
  logic          push1;
  logic          push2;

  logic          eq_in;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          cmp_valid;
  logic          ledpin;
  logic          err;
  logic          busy;
  logic [CW-1:0] match_cnt;
  logic [CW-1:0] miss_cnt;

  logic          eq_s;
  logic [W-1:0]  op_a_s;
  logic [W-1:0]  op_b_s;
  logic          cmp_valid_s;
  logic          ledpin_s;
  logic          err_s;
  logic          busy_s;
  logic [1:0]    match_cnt_s;
  logic [1:0]    miss_cnt_s;

  int n_checks;
  int n_fail;

  // Model comparators
  assign eq_in = (op_a == op_b);
  assign eq_s  = (op_a_s == op_b_s);

  eq_round_ctrl #(.W(W), .CW(CW), .HOLD(HOLD), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .no(no), .push1(push1), .push2(push2),
    .eq_in(eq_in), .op_a(op_a), .op_b(op_b), .cmp_valid(cmp_valid),
    .ledpin(ledpin), .err(err), .busy(busy),
    .match_cnt(match_cnt), .miss_cnt(miss_cnt)
  );

  eq_round_ctrl #(.W(W), .CW(2), .HOLD(HOLD), .TIMEOUT(TIMEOUT)) dut_sat (
    .clk(clk), .reset(reset), .no(no), .push1(push1), .push2(push2),
    .eq_in(eq_s), .op_a(op_a_s), .op_b(op_b_s), .cmp_valid(cmp_valid_s),
    .ledpin(ledpin_s), .err(err_s), .busy(busy_s),
    .match_cnt(match_cnt_s), .miss_cnt(miss_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Enter A: two edges, leaves the controller in WAIT_B.
  task automatic press_a(input logic [W-1:0] v);
    no = v; push1 = 1'b1;
    step();
    push1 = 1'b0;
    step();
  endtask

  // Enter B: one edge, leaves the controller in CMP with cmp_valid high.
  task automatic press_b(input logic [W-1:0] v);
    no = v; push2 = 1'b1;
    step();
    push2 = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 40) begin
      step();
      k++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int cnt;
    int pulses;
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1; no = '0; push1 = 1'b0; push2 = 1'b0;
    step();
    step();

    // Reset state
    check("rst_op_a",  32'(op_a), 32'd0);
    check("rst_op_b",  32'(op_b), 32'd0);
    check("rst_cmpv",  32'(cmp_valid), 32'd0);
    check("rst_led",   32'(ledpin), 32'd0);
    check("rst_err",   32'(err), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_match", 32'(match_cnt), 32'd0);
    check("rst_miss",  32'(miss_cnt), 32'd0);
    reset = 1'b0;
    step();

    // Match round
    press_a(4'b1010);
    check("m_op_a", 32'(op_a), 32'hA);
    check("m_busy", 32'(busy), 32'd1);
    press_b(4'b1010);
    check("m_cmpv", 32'(cmp_valid), 32'd1);
    check("m_op_b", 32'(op_b), 32'hA);
    check("m_led_pre", 32'(ledpin), 32'd0);
    step();
    check("m_cmpv_off", 32'(cmp_valid), 32'd0);
    check("m_match", 32'(match_cnt), 32'd1);
    check("m_miss",  32'(miss_cnt), 32'd0);
    cnt = 0;
    while (ledpin && cnt < 20) begin
      cnt++;
      step();
    end
    check("m_led_cycles", 32'(cnt), 32'(HOLD));
    check("m_idle", 32'(busy), 32'd0);

    // Mismatch round
    press_a(4'b1011);
    press_b(4'b1010);
    check("mm_cmpv", 32'(cmp_valid), 32'd1);
    step();
    check("mm_led",   32'(ledpin), 32'd0);
    check("mm_miss",  32'(miss_cnt), 32'd1);
    check("mm_match", 32'(match_cnt), 32'd1);
    check("mm_err",   32'(err), 32'd0);
    wait_idle("mm_idle");

    // push2 alone in IDLE is ignored
    no = 4'b1111; push2 = 1'b1;
    step();
    check("ord_busy", 32'(busy), 32'd0);
    push2 = 1'b0;
    step();
    check("ord_busy2", 32'(busy), 32'd0);
    check("ord_op_b", 32'(op_b), 32'hA);

    // A overwrite, then B
    press_a(4'b0101);
    press_a(4'b0011);
    check("ow_op_a", 32'(op_a), 32'h3);
    press_b(4'b0011);
    step();
    check("ow_led",   32'(ledpin), 32'd1);
    check("ow_match", 32'(match_cnt), 32'd2);
    wait_idle("ow_idle");

    // Timeout: A entry took 2 edges; 14 more keep us in WAIT_B, the 16th raises err.
    press_a(4'b0010);
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (cmp_valid) pulses++;
    end
    check("to_err_early", 32'(err), 32'd0);
    check("to_busy", 32'(busy), 32'd1);
    step();
    check("to_err", 32'(err), 32'd1);
    cnt = 0;
    while (err && cnt < 20) begin
      if (cmp_valid) pulses++;
      cnt++;
      step();
    end
    check("to_err_cycles", 32'(cnt), 32'(HOLD));
    check("to_no_cmpv", 32'(pulses), 32'd0);
    check("to_match", 32'(match_cnt), 32'd2);
    check("to_miss",  32'(miss_cnt), 32'd1);
    check("to_idle",  32'(busy), 32'd0);

    // Abort during SHOW
    press_a(4'b0110);
    press_b(4'b0110);
    step();
    check("ab_led", 32'(ledpin), 32'd1);
    step();
    no = 4'b1001; push1 = 1'b1;
    step();
    push1 = 1'b0;
    check("ab_led_drop", 32'(ledpin), 32'd0);
    check("ab_busy", 32'(busy), 32'd1);
    check("ab_op_a", 32'(op_a), 32'h9);
    step();
    press_b(4'b1001);
    check("ab_cmpv", 32'(cmp_valid), 32'd1);
    step();
    check("ab_match", 32'(match_cnt), 32'd4);
    wait_idle("ab_idle");

    // Simultaneous edges in IDLE are ignored
    no = 4'b1111; push1 = 1'b1; push2 = 1'b1;
    step();
    check("sim_busy", 32'(busy), 32'd0);
    check("sim_op_a", 32'(op_a), 32'h9);
    push1 = 1'b0; push2 = 1'b0;
    step();

    // Reset in WAIT_B
    press_a(4'b0111);
    check("rw_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rw_busy",  32'(busy), 32'd0);
    check("rw_op_a",  32'(op_a), 32'd0);
    check("rw_match", 32'(match_cnt), 32'd0);
    check("rw_miss",  32'(miss_cnt), 32'd0);
    check("rw_err",   32'(err), 32'd0);
    step();

    // Saturation: five matching rounds
    for (int r = 0; r < 5; r++) begin
      press_a(W'(r + 1));
      press_b(W'(r + 1));
      step();
      wait_idle("sat_idle");
    end
    check("sat_match8", 32'(match_cnt), 32'd5);
    check("sat_match2", 32'(match_cnt_s), 32'd3);
    check("sat_miss2",  32'(miss_cnt_s), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
